alp_uart_rx: RTL and testbench

ALP_UART_RX -- requirements
Module: alp_uart_rx

---
 rtl/alp_uart_pkg.sv | 15 +
 rtl/alp_uart_rx_fifo.sv | 49 ++++
 rtl/alp_uart_rx.sv | 139 +++++++++++++
 tb/tb_alp_uart_rx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alp_uart_pkg.sv
// rtl/alp_uart_pkg.sv - shared types and constants for the UART receiver
package alp_uart_pkg;

   localparam int UART_DATA_BITS            = 8;
   localparam int UART_CLKS_PER_BIT_DEFAULT = 434;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } uart_rx_state_e;

endpackage

// File: rtl/alp_uart_rx_fifo.sv
// rtl/alp_uart_rx_fifo.sv - receive buffer with extra-MSB pointers
module alp_uart_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A pop frees the slot in the same edge, so a full FIFO still accepts a push then
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Head is forced to zero when empty so the output has a defined reset value
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/alp_uart_rx.sv
// rtl/alp_uart_rx.sv - 8N1 UART receiver with buffered byte output
module alp_uart_rx
   import alp_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic [7:0] rdata_o,
   output logic       rvalid_o,
   input  logic       rready_i,
   output logic       frame_err_o,
   output logic       overflow_o,
   output logic       busy_o
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(UART_DATA_BITS);
   localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(UART_DATA_BITS - 1);

   uart_rx_state_e            state_q, state_d;
   logic [TW-1:0]             timer_q, timer_d;
   logic [IW-1:0]             index_q, index_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      rx_meta_q, rx_s;
   logic                      push;
   logic                      frame_err_d, frame_err_q;
   logic                      overflow_q;
   logic                      fifo_full;
   logic                      fifo_empty;

   // Synchronizer idles high so reset never looks like a start bit
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rx_meta_q <= 1'b1;
         rx_s      <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_s      <= rx_meta_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         index_q     <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         index_q     <= index_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= push && fifo_full && !(rvalid_o && rready_i);
      end
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      index_d     = index_q;
      shift_d     = shift_q;
      push        = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            // Sampling mid start bit rejects short low glitches
            if (timer_q == HALF_LAST) begin
               timer_d = '0;
               index_d = '0;
               state_d = rx_s ? IDLE : DATA;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         DATA: begin
            if (timer_q == BIT_LAST) begin
               timer_d          = '0;
               shift_d[index_q] = rx_s;
               if (index_q == IDX_LAST) state_d = STOP;
               else                     index_d = index_q + 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         STOP: begin
            if (timer_q == BIT_LAST) begin
               timer_d = '0;
               if (rx_s) begin
                  push    = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = WAIT_IDLE;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         WAIT_IDLE: begin
            // A held-low break parks here until the line recovers
            timer_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   alp_uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .wdata_i (shift_q),
      .pop_i   (rready_i),
      .rdata_o (rdata_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign rvalid_o    = !fifo_empty;
   assign frame_err_o = frame_err_q;
   assign overflow_o  = overflow_q;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_alp_uart_rx.sv
// tb/tb_alp_uart_rx.sv - directed bench for the UART receiver
module tb_alp_uart_rx;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic [7:0] rdata;
   logic       rvalid;
   logic       rready;
   logic       frame_err;
   logic       overflow;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   int         cyc = 0;
   int         rise_cyc = -1;
   int         ferr_cnt = 0;
   int         ovf_cnt = 0;
   int         ovf_frame = -1;
   int         cur_frame = 0;
   int         stab_err = 0;
   logic [7:0] popped[$];
   logic       prev_hold = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic       prev_valid = 1'b0;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_n;
      int         exp_ferr;
   } vec_t;

   vec_t vecs[6];

   alp_uart_rx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (8)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .rx_i        (rx),
      .rdata_o     (rdata),
      .rvalid_o    (rvalid),
      .rready_i    (rready),
      .frame_err_o (frame_err),
      .overflow_o  (overflow),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   // Inputs change 1 ns after posedge; everything is observed on negedge
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (rvalid && rready) popped.push_back(rdata);
         if (frame_err) ferr_cnt++;
         if (overflow) begin
            ovf_cnt++;
            ovf_frame = cur_frame;
         end
         if (rvalid && !prev_valid) rise_cyc = cyc;
         if (prev_hold && (!rvalid || rdata != prev_data)) stab_err++;
         prev_hold = rvalid && !rready;
      end else begin
         prev_hold = 1'b0;
      end
      prev_valid = rvalid;
      prev_data  = rdata;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop, input int hold_low);
      rx = 1'b0;
      tick(CPB);
      for (int b = 0; b < 8; b++) begin
         rx = data[b];
         tick(CPB);
      end
      rx = stop;
      tick(CPB + hold_low);
      rx = 1'b1;
   endtask

   task automatic clear_counts();
      popped.delete();
      ferr_cnt  = 0;
      ovf_cnt   = 0;
      ovf_frame = -1;
      stab_err  = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rvalid"}, int'(rvalid), 0);
      chk({tag, "_ferr"}, int'(frame_err), 0);
      chk({tag, "_ovf"}, int'(overflow), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_rdata"}, int'(rdata), 0);
   endtask

   initial begin
      int start_cyc;
      vecs[0] = '{data: 8'h00, stop: 1'b1, exp_n: 1, exp_ferr: 0};
      vecs[1] = '{data: 8'hFF, stop: 1'b1, exp_n: 1, exp_ferr: 0};
      vecs[2] = '{data: 8'h3C, stop: 1'b0, exp_n: 0, exp_ferr: 1};
      vecs[3] = '{data: 8'h81, stop: 1'b1, exp_n: 1, exp_ferr: 0};
      vecs[4] = '{data: 8'hC3, stop: 1'b0, exp_n: 0, exp_ferr: 1};
      vecs[5] = '{data: 8'h5A, stop: 1'b1, exp_n: 1, exp_ferr: 0};

      rst_n  = 1'b0;
      rx     = 1'b1;
      rready = 1'b0;
      tick(3);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick(5);

      // Latency: 2 sync + 1 detect + half bit + 9 bits, visible one cycle later
      clear_counts();
      rise_cyc  = -1;
      start_cyc = cyc;
      send_frame(8'hA5, 1'b1, 0);
      tick(10);
      chk("a5_latency", rise_cyc - start_cyc, 3 + CPB / 2 + 9 * CPB + 1);
      chk("a5_rdata", int'(rdata), 8'hA5);
      chk("a5_rvalid", int'(rvalid), 1);
      chk("a5_ferr", ferr_cnt, 0);
      rready = 1'b1;
      tick(2);
      rready = 1'b0;
      chk("a5_popped", popped.size(), 1);

      rready = 1'b1;
      for (int v = 0; v < 6; v++) begin
         clear_counts();
         send_frame(vecs[v].data, vecs[v].stop, 0);
         tick(20);
         chk($sformatf("vec%0d_count", v), popped.size(), vecs[v].exp_n);
         if (popped.size() > 0)
            chk($sformatf("vec%0d_data", v), int'(popped[0]), int'(vecs[v].data));
         chk($sformatf("vec%0d_ferr", v), ferr_cnt, vecs[v].exp_ferr);
      end

      // Short low glitch must be rejected
      clear_counts();
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      tick(30);
      chk("glitch_busy", int'(busy), 0);
      chk("glitch_pops", popped.size(), 0);
      chk("glitch_ferr", ferr_cnt, 0);
      chk("glitch_ovf", ovf_cnt, 0);

      // Bad stop followed by a held-low break, then a good frame
      clear_counts();
      send_frame(8'h3C, 1'b0, 40);
      tick(20);
      send_frame(8'h11, 1'b1, 0);
      tick(20);
      chk("break_ferr", ferr_cnt, 1);
      chk("break_count", popped.size(), 1);
      if (popped.size() > 0) chk("break_data", int'(popped[0]), 8'h11);

      // Overflow on the ninth byte with the consumer stalled
      rready = 1'b0;
      clear_counts();
      for (int i = 1; i <= 9; i++) begin
         cur_frame = i;
         send_frame(8'(i), 1'b1, 0);
         tick(4);
      end
      cur_frame = 0;
      chk("ovf_count", ovf_cnt, 1);
      chk("ovf_frame", ovf_frame, 9);
      chk("ovf_head", int'(rdata), 8'h01);
      rready = 1'b1;
      tick(12);
      rready = 1'b0;
      chk("ovf_drain_count", popped.size(), 8);
      for (int i = 0; i < 8 && i < popped.size(); i++)
         chk($sformatf("ovf_order%0d", i), int'(popped[i]), i + 1);

      // Refill, then pop exactly on the stop-sample edge of 0x0A
      for (int i = 1; i <= 8; i++) begin
         send_frame(8'(i), 1'b1, 0);
         tick(4);
      end
      clear_counts();
      fork
         send_frame(8'h0A, 1'b1, 0);
         begin
            tick(3 + CPB / 2 + 9 * CPB - 1);
            rready = 1'b1;
            tick(1);
            rready = 1'b0;
         end
      join
      tick(10);
      chk("fullpop_ovf", ovf_cnt, 0);
      chk("fullpop_first", popped.size() > 0 ? int'(popped[0]) : -1, 8'h01);
      rready = 1'b1;
      tick(12);
      rready = 1'b0;
      chk("fullpop_total", popped.size(), 9);
      chk("fullpop_last", popped.size() > 0 ? int'(popped[popped.size()-1]) : -1, 8'h0A);

      // Reset during data bit 3 abandons the frame
      clear_counts();
      rx = 1'b0;
      tick(CPB);
      rx = 1'b1;
      tick(3 * CPB + CPB / 2);
      rst_n = 1'b0;
      rx    = 1'b1;
      tick(2);
      check_reset_outputs("midrst");
      rst_n = 1'b1;
      tick(20);
      send_frame(8'h5A, 1'b1, 0);
      rready = 1'b1;
      tick(20);
      rready = 1'b0;
      chk("midrst_count", popped.size(), 1);
      if (popped.size() > 0) chk("midrst_data", int'(popped[0]), 8'h5A);
      chk("midrst_ferr", ferr_cnt, 0);

      chk("hold_stability", stab_err, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
